// File: rtl/simple_processor_pkg.sv
// Shared types and helpers for the simple processor front end: opcode and
// function encodings, sequencer states, and the opcode-to-function mapping.
package simple_processor_pkg;

  localparam int INSTR_WIDTH    = 16;
  localparam int REG_ADDR_WIDTH = 3;
  localparam int IMM_WIDTH      = 6;
  localparam int OPCODE_WIDTH   = 4;

  typedef enum logic [OPCODE_WIDTH-1:0] {
    OP_ADD   = 4'd0,
    OP_ADDI  = 4'd1,
    OP_SUB   = 4'd2,
    OP_AND   = 4'd3,
    OP_OR    = 4'd4,
    OP_XOR   = 4'd5,
    OP_NOT   = 4'd6,
    OP_SLL   = 4'd7,
    OP_SLLI  = 4'd8,
    OP_SLR   = 4'd9,
    OP_SLRI  = 4'd10,
    OP_LOAD  = 4'd11,
    OP_STORE = 4'd12
  } opcode_t;

  typedef enum logic [3:0] {
    FUNC_ADD,
    FUNC_ADDI,
    FUNC_SUB,
    FUNC_AND,
    FUNC_OR,
    FUNC_XOR,
    FUNC_NOT,
    FUNC_SLL,
    FUNC_SLLI,
    FUNC_SLR,
    FUNC_SLRI,
    FUNC_LOAD,
    FUNC_STORE
  } func_t;

  typedef enum logic [1:0] {
    FETCH,
    EXEC,
    MEM,
    HALT
  } fd_state_t;

  function automatic func_t opcode_to_func(input logic [OPCODE_WIDTH-1:0] op);
    func_t f;
    // NOTE: a default ahead of the case keeps this combinational for every opcode.
    f = FUNC_ADD;
    case (op)
      OP_ADD:   f = FUNC_ADD;
      OP_ADDI:  f = FUNC_ADDI;
      OP_SUB:   f = FUNC_SUB;
      OP_AND:   f = FUNC_AND;
      OP_OR:    f = FUNC_OR;
      OP_XOR:   f = FUNC_XOR;
      OP_NOT:   f = FUNC_NOT;
      OP_SLL:   f = FUNC_SLL;
      OP_SLLI:  f = FUNC_SLLI;
      OP_SLR:   f = FUNC_SLR;
      OP_SLRI:  f = FUNC_SLRI;
      OP_LOAD:  f = FUNC_LOAD;
      OP_STORE: f = FUNC_STORE;
      default:  f = FUNC_ADD;
    endcase
    return f;
  endfunction

  function automatic logic is_illegal_opcode(input logic [OPCODE_WIDTH-1:0] op);
    return op > OP_STORE;
  endfunction

endpackage

// File: rtl/fetch_decode_ctrl_if.sv
// Bus bundle between the fetch/decode sequencer and its IMEM, DMEM and
// execution-unit neighbours. master = sequencer, slave = environment.
interface fetch_decode_ctrl_if #(
  parameter int IMEM_ADDR_WIDTH = 8,
  parameter int INSTR_WIDTH     = 16
);
  import simple_processor_pkg::*;

  logic                       imem_req_o;
  logic [IMEM_ADDR_WIDTH-1:0] imem_addr_o;
  logic [INSTR_WIDTH-1:0]     imem_rdata_i;
  logic                       imem_ack_i;
  logic                       dmem_ack_i;
  logic                       dmem_req_o;
  func_t                      func_o;
  logic [2:0]                 rs1_addr_o;
  logic [2:0]                 rs2_addr_o;
  logic [2:0]                 rd_addr_o;
  logic [5:0]                 imm_o;
  logic                       rd_we_o;
  logic [IMEM_ADDR_WIDTH-1:0] pc_o;
  logic                       halted_o;

  modport master (
    output imem_req_o, imem_addr_o, dmem_req_o, func_o, rs1_addr_o, rs2_addr_o,
           rd_addr_o, imm_o, rd_we_o, pc_o, halted_o,
    input  imem_rdata_i, imem_ack_i, dmem_ack_i
  );

  modport slave (
    input  imem_req_o, imem_addr_o, dmem_req_o, func_o, rs1_addr_o, rs2_addr_o,
           rd_addr_o, imm_o, rd_we_o, pc_o, halted_o,
    output imem_rdata_i, imem_ack_i, dmem_ack_i
  );

endinterface

// File: rtl/fetch_decode_ctrl_instr_decoder.sv
// Combinational instruction decoder: splits the instruction register into
// function, register indices and raw immediate, and classifies the opcode.
module instr_decoder
  import simple_processor_pkg::*;
(
  input  logic [INSTR_WIDTH-1:0]    instr,
  output func_t                     func,
  output logic [REG_ADDR_WIDTH-1:0] rd_addr,
  output logic [REG_ADDR_WIDTH-1:0] rs1_addr,
  output logic [REG_ADDR_WIDTH-1:0] rs2_addr,
  output logic [IMM_WIDTH-1:0]      imm,
  output logic                      illegal,
  output logic                      is_mem,
  output logic                      is_load
);

  logic [OPCODE_WIDTH-1:0] opcode;

  assign opcode   = instr[15:12];
  assign rd_addr  = instr[11:9];
  assign rs1_addr = instr[8:6];
  assign rs2_addr = instr[5:3];
  // The immediate overlaps rs2; sign extension is left to the execution unit.
  assign imm      = instr[5:0];

  assign func     = opcode_to_func(opcode);
  assign illegal  = is_illegal_opcode(opcode);
  assign is_load  = (opcode == OP_LOAD);
  assign is_mem   = (opcode == OP_LOAD) || (opcode == OP_STORE);

endmodule

// File: rtl/fetch_decode_ctrl.sv
// Fetch/decode sequencer: fetches over IMEM req/ack, holds the decoded
// instruction through EXEC/MEM, strobes the register write and advances the PC.
module fetch_decode_ctrl #(
  parameter int                         IMEM_ADDR_WIDTH = 8,
  parameter int                         INSTR_WIDTH     = 16,
  parameter logic [IMEM_ADDR_WIDTH-1:0] RESET_PC        = '0
) (
  input logic                  clk_i,
  input logic                  rst_i,
  fetch_decode_ctrl_if.master  bus
);
  import simple_processor_pkg::*;

  fd_state_t                  state;
  logic [IMEM_ADDR_WIDTH-1:0] pc;
  logic [INSTR_WIDTH-1:0]     ir;

  func_t      dec_func;
  logic [2:0] dec_rd;
  logic [2:0] dec_rs1;
  logic [2:0] dec_rs2;
  logic [5:0] dec_imm;
  logic       dec_illegal;
  logic       dec_is_mem;
  logic       dec_is_load;

  instr_decoder u_decoder (
    .instr    (ir[15:0]),
    .func     (dec_func),
    .rd_addr  (dec_rd),
    .rs1_addr (dec_rs1),
    .rs2_addr (dec_rs2),
    .imm      (dec_imm),
    .illegal  (dec_illegal),
    .is_mem   (dec_is_mem),
    .is_load  (dec_is_load)
  );

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= FETCH;
      pc    <= RESET_PC;
      ir    <= '0;
    end else begin
      case (state)
        FETCH: begin
          if (bus.imem_ack_i) begin
            ir    <= bus.imem_rdata_i;
            state <= EXEC;
          end
        end
        EXEC: begin
          if (dec_illegal) begin
            state <= HALT;
          end else if (dec_is_mem) begin
            state <= MEM;
          end else begin
            pc    <= pc + 1'b1;
            state <= FETCH;
          end
        end
        MEM: begin
          if (bus.dmem_ack_i) begin
            pc    <= pc + 1'b1;
            state <= FETCH;
          end
        end
        HALT:    state <= HALT;
        default: state <= FETCH;
      endcase
    end
  end

  // Strobes decode straight from state so a LOAD writes back in its dmem ack
  // cycle; reset masks them so an abandoned transaction never writes.
  assign bus.imem_req_o  = !rst_i && (state == FETCH);
  assign bus.dmem_req_o  = !rst_i && (state == MEM);
  assign bus.rd_we_o     = !rst_i &&
                           (((state == EXEC) && !dec_illegal && !dec_is_mem) ||
                            ((state == MEM) && dec_is_load && bus.dmem_ack_i));
  assign bus.halted_o    = (state == HALT);

  assign bus.imem_addr_o = pc;
  assign bus.pc_o        = pc;
  assign bus.func_o      = dec_func;
  assign bus.rd_addr_o   = dec_rd;
  assign bus.rs1_addr_o  = dec_rs1;
  assign bus.rs2_addr_o  = dec_rs2;
  assign bus.imm_o       = dec_imm;

endmodule
